// File: rtl/mem_loader_pkg.sv
// Shared constants for the LC-3 object-stream memory loader.
package mem_loader_pkg;

  localparam int WORD_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ORIG_HI = 3'd1,
    ORIG_LO = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/mem_loader_word_assembler.sv
// Byte-pair to 16-bit word latch; big-endian, high byte first.
module word_assembler
  import mem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_byte,
  input  logic                  load_hi,
  input  logic                  load_lo,
  output logic [WORD_WIDTH-1:0] word
);

  logic [7:0] hi_q;
  logic [7:0] lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (load_hi) hi_q <= in_byte;
      if (load_lo) lo_q <= in_byte;
    end
  end

  assign word = {hi_q, lo_q};

endmodule

// File: rtl/mem_loader.sv
// Loads program memory from an LC-3 object byte stream (origin word, then data words).
// Optional running data checksum when MEM_LOADER_CHECKSUM_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start after reset
// ORIG_HI | expecting origin high byte
// ORIG_LO | expecting origin low byte
// DATA_HI | expecting data word high byte
// DATA_LO | expecting data word low byte
// WRITE   | holding mem_we until mem_ack
// DONE    | load finished, err valid
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] origin,
  output logic [15:0]           word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           checksum
);

  state_t state, state_nxt;

  logic                  accept;
  logic                  load_hi;
  logic                  load_lo;
  logic                  restart;
  logic                  write_ack;
  logic                  last_q;
  logic [15:0]           orig_word;
  logic [WORD_WIDTH-1:0] word;

  word_assembler u_word_assembler (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_byte (in_data),
    .load_hi (load_hi),
    .load_lo (load_lo),
    .word    (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    load_hi   = 1'b0;
    load_lo   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ORIG_HI;
      end
      ORIG_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? DONE : ORIG_LO;
      end
      ORIG_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? DONE : DATA_HI;
      end
      DATA_HI: begin
        in_ready = 1'b1;
        load_hi  = in_valid && !in_last;
        if (in_valid) state_nxt = in_last ? DONE : DATA_LO;
      end
      DATA_LO: begin
        in_ready = 1'b1;
        load_lo  = in_valid;
        if (in_valid) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (mem_ack) state_nxt = last_q ? DONE : DATA_HI;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_nxt = ORIG_HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign restart   = start && (state == IDLE || state == DONE);
  assign write_ack = (state == WRITE) && mem_ack;

  // A trailing in_last on any byte other than a word's low byte is a truncated stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orig_word  <= '0;
      mem_addr   <= '0;
      word_count <= '0;
      err        <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      if (restart) begin
        err        <= 1'b0;
        word_count <= '0;
      end
      if (accept) begin
        case (state)
          ORIG_HI: begin
            orig_word[15:8] <= in_data;
            if (in_last) err <= 1'b1;
          end
          ORIG_LO: begin
            orig_word[7:0] <= in_data;
            mem_addr       <= ADDR_WIDTH'({orig_word[15:8], in_data});
            if (in_last) err <= 1'b1;
          end
          DATA_HI: if (in_last) err <= 1'b1;
          DATA_LO: last_q <= in_last;
          default: ;
        endcase
      end
      if (write_ack) begin
        mem_addr   <= mem_addr + ADDR_WIDTH'(1);
        word_count <= word_count + 16'd1;
      end
    end
  end

  assign origin   = ADDR_WIDTH'(orig_word);
  assign mem_data = DATA_WIDTH'(word);

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         checksum_q <= '0;
    else if (restart)   checksum_q <= '0;
    else if (write_ack) checksum_q <= checksum_q + 16'(word);
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
